// File: rtl/register_read_pkg.sv
// register_read_pkg: shared types and constants for the register-read stage.
//   NUM_REGS  - architectural register count (16)
//   reg_code_t - 4-bit register code
//   word_t     - 64-bit data word
//   rr_state_e - output-slot state {EMPTY, FULL}
//   reg_onehot - one-hot mask of a register code, gated by an enable
package register_read_pkg;
    localparam int NUM_REGS = 16;
    localparam int REG_W    = 4;
    localparam int WORD_W   = 64;

    typedef logic [REG_W-1:0]  reg_code_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} rr_state_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_code_t code, input logic en);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (en) m[code] = 1'b1;
        return m;
    endfunction
endpackage

// File: rtl/register_read_if.sv
// register_read_if: bundles the decode-side, writeback-side, execute-side
// and status signals of the register-read stage.
//   slave  - seen by register_read (inputs from decode/writeback/execute)
//   master - seen by the driver of the stage (testbench / surrounding pipe)
interface register_read_if;
    import register_read_pkg::*;

    // decode side
    logic      decodeValidIn;
    word_t     currentRipIn;
    reg_code_t sourceReg1In, sourceReg2In;
    logic      sourceReg1ValidIn, sourceReg2ValidIn;
    reg_code_t destRegIn, destRegSpecialIn;
    logic      destRegValidIn, destRegSpecialValidIn;
    logic [NUM_REGS-1:0][WORD_W-1:0] regFileIn;
    // writeback side
    logic      wbValidIn;
    reg_code_t wbDestRegIn, wbDestRegSpecialIn;
    logic      wbDestRegSpecialValidIn;
    word_t     wbResultIn, wbResultSpecialIn;
    // execute / control
    logic      execReadyIn;
    logic      killIn;
    // outputs
    logic      readReadyOut;
    logic      readValidOut;
    word_t     currentRipOut, operand1Out, operand2Out;
    reg_code_t destRegOut, destRegSpecialOut;
    logic      destRegValidOut, destRegSpecialValidOut;
    logic [NUM_REGS-1:0] regInUseBitMapOut;
    logic [15:0] stallCountOut;

    modport slave (
        input  decodeValidIn, currentRipIn, sourceReg1In, sourceReg2In,
               sourceReg1ValidIn, sourceReg2ValidIn, destRegIn, destRegSpecialIn,
               destRegValidIn, destRegSpecialValidIn, regFileIn,
               wbValidIn, wbDestRegIn, wbDestRegSpecialIn, wbDestRegSpecialValidIn,
               wbResultIn, wbResultSpecialIn, execReadyIn, killIn,
        output readReadyOut, readValidOut, currentRipOut, operand1Out, operand2Out,
               destRegOut, destRegSpecialOut, destRegValidOut, destRegSpecialValidOut,
               regInUseBitMapOut, stallCountOut
    );

    modport master (
        output decodeValidIn, currentRipIn, sourceReg1In, sourceReg2In,
               sourceReg1ValidIn, sourceReg2ValidIn, destRegIn, destRegSpecialIn,
               destRegValidIn, destRegSpecialValidIn, regFileIn,
               wbValidIn, wbDestRegIn, wbDestRegSpecialIn, wbDestRegSpecialValidIn,
               wbResultIn, wbResultSpecialIn, execReadyIn, killIn,
        input  readReadyOut, readValidOut, currentRipOut, operand1Out, operand2Out,
               destRegOut, destRegSpecialOut, destRegValidOut, destRegSpecialValidOut,
               regInUseBitMapOut, stallCountOut
    );
endinterface

// File: rtl/register_read_scoreboard.sv
// reg_scoreboard: per-register pending-writer bits.
//   clk, rst_n          - clock, async active-low reset
//   rel_*               - writeback release (normal + special destination)
//   set_en, dst*        - instruction accepted: mark its destinations busy
//   src*/dst* (query)   - operands of the instruction currently offered
//   flush               - clear every busy bit
//   hazard              - offered instruction touches a busy register
//   busy_o              - current busy bitmap
module reg_scoreboard
    import register_read_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rel_valid,
    input  reg_code_t rel_reg,
    input  logic      rel_sp_valid,
    input  reg_code_t rel_sp_reg,
    input  logic      set_en,
    input  reg_code_t dst,
    input  logic      dst_valid,
    input  reg_code_t dst_sp,
    input  logic      dst_sp_valid,
    input  reg_code_t src1,
    input  logic      src1_valid,
    input  reg_code_t src2,
    input  logic      src2_valid,
    input  logic      flush,
    output logic      hazard,
    output logic [NUM_REGS-1:0] busy_o
);
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] rel_mask, busy_rel, query_mask, dst_mask, set_mask;

    // Kept as separate assigns: set_en is derived from hazard upstream, so
    // the hazard and next-state paths must not share one process.
    assign rel_mask   = reg_onehot(rel_reg, rel_valid)
                      | reg_onehot(rel_sp_reg, rel_valid & rel_sp_valid);
    // Released registers are already free for the instruction being offered.
    assign busy_rel   = busy_q & ~rel_mask;
    assign dst_mask   = reg_onehot(dst, dst_valid) | reg_onehot(dst_sp, dst_sp_valid);
    assign query_mask = reg_onehot(src1, src1_valid) | reg_onehot(src2, src2_valid) | dst_mask;
    assign hazard     = |(busy_rel & query_mask);
    assign set_mask   = set_en ? dst_mask : '0;
    // Set is OR'ed after the release, so a same-cycle set wins.
    assign busy_d     = flush ? '0 : (busy_rel | set_mask);
    assign busy_o     = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end
endmodule

// File: rtl/register_read.sv
// register_read: register-read pipeline stage. Reads operands for the decoded
// instruction (with writeback bypass), blocks on scoreboard hazards, and
// holds one instruction in an output register for the execute stage.
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   rr    - register_read_if.slave: decode/writeback/execute signals + outputs
module register_read
    import register_read_pkg::*;
(
    input  logic clk,
    input  logic reset,
    register_read_if.slave rr
);
    rr_state_e state_q, state_d;
    word_t     rip_q, rip_d, op1_q, op1_d, op2_q, op2_d;
    reg_code_t dst_q, dst_d, dst_sp_q, dst_sp_d;
    logic      dst_v_q, dst_v_d, dst_sp_v_q, dst_sp_v_d;
    logic [15:0] stall_q, stall_d;

    logic  hazard, slot_free, ready, accept;
    word_t op1_sel, op2_sel;
    logic [NUM_REGS-1:0] busy;

    reg_scoreboard u_sb (
        .clk          (clk),
        .rst_n        (reset),
        .rel_valid    (rr.wbValidIn),
        .rel_reg      (rr.wbDestRegIn),
        .rel_sp_valid (rr.wbDestRegSpecialValidIn),
        .rel_sp_reg   (rr.wbDestRegSpecialIn),
        .set_en       (accept),
        .dst          (rr.destRegIn),
        .dst_valid    (rr.destRegValidIn),
        .dst_sp       (rr.destRegSpecialIn),
        .dst_sp_valid (rr.destRegSpecialValidIn),
        .src1         (rr.sourceReg1In),
        .src1_valid   (rr.sourceReg1ValidIn),
        .src2         (rr.sourceReg2In),
        .src2_valid   (rr.sourceReg2ValidIn),
        .flush        (rr.killIn),
        .hazard       (hazard),
        .busy_o       (busy)
    );

    // Bypass priority: special writeback, then normal writeback, then regfile.
    function automatic word_t pick_operand(
        input reg_code_t src, input logic src_v,
        input logic wb_v, input reg_code_t wb_d, input word_t wb_r,
        input logic wb_sv, input reg_code_t wb_sd, input word_t wb_sr,
        input logic [NUM_REGS-1:0][WORD_W-1:0] rf
    );
        if (!src_v)                        return '0;
        else if (wb_v && wb_sv && src == wb_sd) return wb_sr;
        else if (wb_v && src == wb_d)      return wb_r;
        else                               return rf[src];
    endfunction

    assign op1_sel = pick_operand(rr.sourceReg1In, rr.sourceReg1ValidIn,
                                  rr.wbValidIn, rr.wbDestRegIn, rr.wbResultIn,
                                  rr.wbDestRegSpecialValidIn, rr.wbDestRegSpecialIn,
                                  rr.wbResultSpecialIn, rr.regFileIn);
    assign op2_sel = pick_operand(rr.sourceReg2In, rr.sourceReg2ValidIn,
                                  rr.wbValidIn, rr.wbDestRegIn, rr.wbResultIn,
                                  rr.wbDestRegSpecialValidIn, rr.wbDestRegSpecialIn,
                                  rr.wbResultSpecialIn, rr.regFileIn);

    assign slot_free = (state_q == EMPTY) || rr.execReadyIn;
    assign ready     = slot_free && !hazard && !rr.killIn;
    assign accept    = rr.decodeValidIn && ready;

    always_comb begin
        state_d    = state_q;
        rip_d      = rip_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        dst_d      = dst_q;
        dst_sp_d   = dst_sp_q;
        dst_v_d    = dst_v_q;
        dst_sp_v_d = dst_sp_v_q;
        stall_d    = stall_q;

        if (rr.killIn) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d    = FULL;
            rip_d      = rr.currentRipIn;
            op1_d      = op1_sel;
            op2_d      = op2_sel;
            dst_d      = rr.destRegIn;
            dst_sp_d   = rr.destRegSpecialIn;
            dst_v_d    = rr.destRegValidIn;
            dst_sp_v_d = rr.destRegSpecialValidIn;
        end else if (state_q == FULL && rr.execReadyIn) begin
            state_d = EMPTY;
        end

        if (rr.decodeValidIn && hazard && !rr.killIn && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= EMPTY;
            rip_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            dst_q      <= '0;
            dst_sp_q   <= '0;
            dst_v_q    <= 1'b0;
            dst_sp_v_q <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            rip_q      <= rip_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            dst_q      <= dst_d;
            dst_sp_q   <= dst_sp_d;
            dst_v_q    <= dst_v_d;
            dst_sp_v_q <= dst_sp_v_d;
            stall_q    <= stall_d;
        end
    end

    assign rr.readReadyOut           = ready;
    assign rr.readValidOut           = (state_q == FULL);
    assign rr.currentRipOut          = rip_q;
    assign rr.operand1Out            = op1_q;
    assign rr.operand2Out            = op2_q;
    assign rr.destRegOut             = dst_q;
    assign rr.destRegSpecialOut      = dst_sp_q;
    assign rr.destRegValidOut        = dst_v_q;
    assign rr.destRegSpecialValidOut = dst_sp_v_q;
    assign rr.regInUseBitMapOut      = busy;
    assign rr.stallCountOut          = stall_q;
endmodule

// File: doc/register_read.md
REGISTER_READ -- requirements
Module: register_read

Interface
REQ-001 clk  in  1  sole clock, rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset.
REQ-003 decodeValidIn  in  1  decoded instruction present.
REQ-004 currentRipIn  in  64  instruction RIP.
REQ-005 sourceReg1In / sourceReg2In  in  4 each  source register codes.
REQ-006 sourceReg1ValidIn / sourceReg2ValidIn  in  1 each  source used.
REQ-007 destRegIn / destRegSpecialIn  in  4 each  destination register codes.
REQ-008 destRegValidIn / destRegSpecialValidIn  in  1 each  destination written.
REQ-009 regFileIn  in  16 x 64  architectural register file contents.
REQ-010 wbValidIn  in  1  writeback retiring an instruction this cycle.
REQ-011 wbDestRegIn / wbDestRegSpecialIn  in  4 each  retiring destinations.
REQ-012 wbDestRegSpecialValidIn  in  1  special destination retiring.
REQ-013 wbResultIn / wbResultSpecialIn  in  64 each  retiring values.
REQ-014 execReadyIn  in  1  execute stage accepts this cycle.
REQ-015 killIn  in  1  pipeline flush.
REQ-016 readReadyOut  out  1  decode may hand over (combinational).
REQ-017 readValidOut  out  1  output register holds an instruction.
REQ-018 currentRipOut  out  64; operand1Out / operand2Out  out  64 each.
REQ-019 destRegOut, destRegSpecialOut  out  4 each; destRegValidOut, destRegSpecialValidOut  out  1 each.
REQ-020 regInUseBitMapOut  out  16 x 1  current scoreboard.
REQ-021 stallCountOut  out  16  hazard-stall cycle counter.

Function
REQ-022 Internal 16-bit scoreboard busy[]; bit set = register has a pending writer.
REQ-023 Release: when wbValidIn=1, clear busy[wbDestRegIn]; also busy[wbDestRegSpecialIn] if wbDestRegSpecialValidIn=1.
REQ-024 Hazard = any valid source or valid destination whose busy bit is set after this cycle's release (released registers are not hazards).
REQ-025 Operand select per source: if that register is released this cycle, use matching wbResultIn/wbResultSpecialIn (special wins if both codes match); else regFileIn; invalid source -> 0.
REQ-026 States: EMPTY (readValidOut=0), FULL (readValidOut=1).
REQ-027 slotFree = (state==EMPTY) or execReadyIn.
REQ-028 readReadyOut = slotFree and not hazard and not killIn.
REQ-029 Accept = decodeValidIn and readReadyOut; on accept, load output register next edge, state->FULL, set busy for each valid destination.
REQ-030 FULL with execReadyIn=1 and no accept -> EMPTY; FULL with execReadyIn=0 -> hold all outputs stable.
REQ-031 Same-register release and set in one cycle: set wins.
REQ-032 Latency: accept at edge N -> readValidOut=1 after edge N; one instruction per cycle sustained.
REQ-033 stallCountOut increments when decodeValidIn=1 and hazard=1 and killIn=0; saturates at 0xFFFF.
REQ-034 killIn=1: next edge state->EMPTY, busy[] all cleared, no accept; stallCountOut unchanged.
REQ-035 killIn and wbValidIn together: kill dominates (all bits cleared).

Reset
REQ-036 While reset=0: state EMPTY, readValidOut=0, all data outputs 0, busy[] all 0, stallCountOut=0, independent of clk.
REQ-037 Reset asserted mid-operation discards held instruction; first accept possible on the first edge after deassertion.

Structure
REQ-038 Shared package: register-code type (4 bits), NUM_REGS=16, state enum {EMPTY, FULL}, 64-bit word type.
REQ-039 One sub-module reg_scoreboard: holds busy[], applies release/set/flush, outputs hazard and bitmap.
REQ-040 Operand select and handshake logic stay in register_read.

Verification
REQ-041 Reset, then decodeValidIn=1, src1=R3 (regFileIn[3]=0x11), dst=R5, execReadyIn=1 -> next cycle readValidOut=1, operand1Out=0x11, busy[5]=1.
REQ-042 Next instruction sources R5 while busy[5]=1, no writeback -> readReadyOut=0; stallCountOut increments by 1 per cycle.
REQ-043 Same as 042 with wbValidIn=1, wbDestRegIn=5, wbResultIn=0xAB -> accepted that cycle, operand1Out=0xAB.
REQ-044 readValidOut=1 with execReadyIn=0 for 3 cycles -> outputs stable, readReadyOut=0; execReadyIn=1 -> back-to-back accept.
REQ-045 killIn=1 with busy=0x0028 and readValidOut=1 -> next cycle readValidOut=0, busy=0, no accept.
REQ-046 Reset pulsed low between edges while FULL -> outputs and bitmap 0 immediately.
